// File: rtl/lsq_store_forward.sv
// Store-to-load forwarding lookup for an LSQ: S1 request register, S2 older-store search + response register.
// Optional per-kind response counters are compiled in when LSQ_FWD_STATS_EN is defined.
module lsq_store_forward #(
  parameter int DEPTH  = 8,
  parameter int TAG_W  = $clog2(DEPTH),
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic [TAG_W-1:0]          head_ptr,
  input  logic [DEPTH-1:0]          ent_valid,
  input  logic [DEPTH-1:0]          ent_is_store,
  input  logic [DEPTH*ADDR_W-1:0]   ent_addr,
  input  logic [DEPTH*DATA_W/8-1:0] ent_be,
  input  logic [DEPTH-1:0]          ent_data_valid,
  input  logic [DEPTH*DATA_W-1:0]   ent_data,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [TAG_W-1:0]          req_tag,
  input  logic [ADDR_W-1:0]         req_addr,
  input  logic [DATA_W/8-1:0]       req_be,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [TAG_W-1:0]          resp_tag,
  output logic [1:0]                resp_kind,
  output logic [DATA_W-1:0]         resp_data,
  output logic [TAG_W-1:0]          resp_src
`ifdef LSQ_FWD_STATS_EN
  ,
  output logic [31:0]               stat_hit,
  output logic [31:0]               stat_miss,
  output logic [31:0]               stat_stall
`endif
);

  localparam int BE_W = DATA_W / 8;
  localparam logic [1:0] KIND_MISS  = 2'b00;
  localparam logic [1:0] KIND_HIT   = 2'b01;
  localparam logic [1:0] KIND_STALL = 2'b10;

  logic              s1_valid_q;
  logic [TAG_W-1:0]  s1_tag_q;
  logic [ADDR_W-1:0] s1_addr_q;
  logic [BE_W-1:0]   s1_be_q;

  logic              resp_valid_q;
  logic [TAG_W-1:0]  resp_tag_q;
  logic [1:0]        resp_kind_q;
  logic [DATA_W-1:0] resp_data_q;
  logic [TAG_W-1:0]  resp_src_q;

  logic              s2_advance_s;
  logic [DEPTH-1:0]  cand_s;
  logic [TAG_W-1:0]  win_s;
  logic              found_s;
  logic [TAG_W-1:0]  sel_s;
  logic [BE_W-1:0]   sel_be_s;
  logic              sel_dv_s;
  logic [DATA_W-1:0] sel_data_s;
  logic [1:0]        resp_kind_d;
  logic [DATA_W-1:0] resp_data_d;

  assign s2_advance_s = !resp_valid_q || resp_ready;
  assign req_ready    = !s1_valid_q || s2_advance_s;

  // Window length = number of entries strictly older than the load (0 when tag == head).
  assign win_s = s1_tag_q - head_ptr;

  for (genvar i = 0; i < DEPTH; i++) begin : g_cand
    assign cand_s[i] = ent_valid[i] && ent_is_store[i] &&
                       (ent_addr[i*ADDR_W +: ADDR_W] == s1_addr_q) &&
                       (|(ent_be[i*BE_W +: BE_W] & s1_be_q));
  end

  // Walk from head toward the load; later matches overwrite earlier, so the youngest wins.
  always_comb begin
    found_s = 1'b0;
    sel_s   = '0;
    for (int o = 0; o < DEPTH; o++) begin
      if ((o < int'(win_s)) && cand_s[head_ptr + TAG_W'(o)]) begin
        found_s = 1'b1;
        sel_s   = head_ptr + TAG_W'(o);
      end else begin
        found_s = found_s;
      end
    end
  end

  // Mux out the selected entry's byte enables, data-ready flag and data.
  always_comb begin
    sel_be_s   = '0;
    sel_dv_s   = 1'b0;
    sel_data_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sel_s == TAG_W'(i)) begin
        sel_be_s   = ent_be[i*BE_W +: BE_W];
        sel_dv_s   = ent_data_valid[i];
        sel_data_s = ent_data[i*DATA_W +: DATA_W];
      end else begin
        sel_dv_s = sel_dv_s;
      end
    end
  end

  // Classify the lookup and mask forwarded data down to the load's bytes.
  always_comb begin
    resp_kind_d = KIND_MISS;
    resp_data_d = '0;
    if (!found_s) begin
      resp_kind_d = KIND_MISS;
    end else if (((sel_be_s & s1_be_q) == s1_be_q) && sel_dv_s) begin
      resp_kind_d = KIND_HIT;
      for (int b = 0; b < BE_W; b++) begin
        resp_data_d[b*8 +: 8] = s1_be_q[b] ? sel_data_s[b*8 +: 8] : 8'h00;
      end
    end else begin
      resp_kind_d = KIND_STALL;
    end
  end

  // Pipeline registers: S1 holds the request, S2 holds the response until it is taken.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q   <= 1'b0;
      s1_tag_q     <= '0;
      s1_addr_q    <= '0;
      s1_be_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_tag_q   <= '0;
      resp_kind_q  <= KIND_MISS;
      resp_data_q  <= '0;
      resp_src_q   <= '0;
    end else if (flush) begin
      s1_valid_q   <= 1'b0;
      resp_valid_q <= 1'b0;
    end else begin
      if (s2_advance_s) begin
        resp_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          resp_tag_q  <= s1_tag_q;
          resp_kind_q <= resp_kind_d;
          resp_data_q <= resp_data_d;
          resp_src_q  <= sel_s;
        end
      end
      if (req_ready) begin
        s1_valid_q <= req_valid;
        if (req_valid) begin
          s1_tag_q  <= req_tag;
          s1_addr_q <= req_addr;
          s1_be_q   <= req_be;
        end
      end
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_tag   = resp_tag_q;
  assign resp_kind  = resp_kind_q;
  assign resp_data  = resp_data_q;
  assign resp_src   = resp_src_q;

`ifdef LSQ_FWD_STATS_EN
  logic [31:0] stat_hit_q;
  logic [31:0] stat_miss_q;
  logic [31:0] stat_stall_q;
  logic        fire_s;

  assign fire_s = resp_valid_q && resp_ready;

  // Saturating per-kind counters of completed response handshakes; only reset clears them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_hit_q   <= 32'd0;
      stat_miss_q  <= 32'd0;
      stat_stall_q <= 32'd0;
    end else if (fire_s) begin
      case (resp_kind_q)
        KIND_HIT:   if (stat_hit_q   != 32'hFFFF_FFFF) stat_hit_q   <= stat_hit_q   + 32'd1;
        KIND_MISS:  if (stat_miss_q  != 32'hFFFF_FFFF) stat_miss_q  <= stat_miss_q  + 32'd1;
        KIND_STALL: if (stat_stall_q != 32'hFFFF_FFFF) stat_stall_q <= stat_stall_q + 32'd1;
        default:    stat_hit_q <= stat_hit_q;
      endcase
    end
  end

  assign stat_hit   = stat_hit_q;
  assign stat_miss  = stat_miss_q;
  assign stat_stall = stat_stall_q;
`endif

endmodule

// File: tb/tb_lsq_store_forward.sv
// Bench for lsq_store_forward (DEPTH=8): directed table, hold/flush/reset sequences, randomized run vs a reference model.
module tb_lsq_store_forward;

  logic          clk;
  logic          reset;
  logic          flush;
  logic [2:0]    head_ptr;
  logic [7:0]    ent_valid, ent_is_store, ent_data_valid;
  logic [255:0]  ent_addr;
  logic [31:0]   ent_be;
  logic [255:0]  ent_data;
  logic          req_valid, req_ready;
  logic [2:0]    req_tag;
  logic [31:0]   req_addr;
  logic [3:0]    req_be;
  logic          resp_valid, resp_ready;
  logic [2:0]    resp_tag, resp_src;
  logic [1:0]    resp_kind;
  logic [31:0]   resp_data;
`ifdef LSQ_FWD_STATS_EN
  logic [31:0]   stat_hit, stat_miss, stat_stall;
`endif

  lsq_store_forward #(.DEPTH(8), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .flush(flush), .head_ptr(head_ptr),
    .ent_valid(ent_valid), .ent_is_store(ent_is_store), .ent_addr(ent_addr),
    .ent_be(ent_be), .ent_data_valid(ent_data_valid), .ent_data(ent_data),
    .req_valid(req_valid), .req_ready(req_ready), .req_tag(req_tag),
    .req_addr(req_addr), .req_be(req_be), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_tag(resp_tag), .resp_kind(resp_kind),
    .resp_data(resp_data), .resp_src(resp_src)
`ifdef LSQ_FWD_STATS_EN
    , .stat_hit(stat_hit), .stat_miss(stat_miss), .stat_stall(stat_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  head, tag;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [7:0]  valid, store, dv, match;
    logic [31:0] ebe;
    logic [1:0]  kind;
    logic [2:0]  src;
    logic [31:0] data;
  } vec_t;

  typedef struct packed {
    logic [2:0]  tag;
    logic [1:0]  kind;
    logic [2:0]  src;
    logic [31:0] data;
  } exp_t;

  vec_t  tv[12];
  exp_t  exp_q[$];
  int    n_checks = 0;
  int    n_pass   = 0;
  int    n_resp   = 0;
  logic        held_prev = 1'b0;
  logic [40:0] held_snap = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference: scan backward from the load toward head; the first matching store is the youngest.
  task automatic ref_lookup(input logic [2:0] head, input logic [2:0] tag, input logic [31:0] addr,
                            input logic [3:0] be, output logic [1:0] kind, output logic [2:0] src,
                            output logic [31:0] data);
    int n, idx;
    logic [3:0] ebe;
    kind = 2'b00; src = 3'd0; data = 32'd0;
    n = (int'(tag) - int'(head) + 8) % 8;
    for (int k = 1; k <= n; k++) begin
      idx = (int'(tag) - k + 8) % 8;
      ebe = ent_be[idx*4 +: 4];
      if (ent_valid[idx] && ent_is_store[idx] && ent_addr[idx*32 +: 32] == addr && (ebe & be) != 4'h0) begin
        src = 3'(idx);
        if ((ebe & be) == be && ent_data_valid[idx]) begin
          kind = 2'b01;
          for (int b = 0; b < 4; b++)
            if (be[b]) data[b*8 +: 8] = ent_data[idx*256/8 + b*8 +: 8];
        end else begin
          kind = 2'b10;
        end
        return;
      end
    end
  endtask

  task automatic set_entries(input int v);
    head_ptr = tv[v].head; ent_valid = tv[v].valid; ent_is_store = tv[v].store;
    ent_data_valid = tv[v].dv; ent_be = tv[v].ebe;
    for (int i = 0; i < 8; i++)
      ent_addr[i*32 +: 32] = tv[v].match[i] ? tv[v].addr : (tv[v].addr ^ 32'h0000_0100);
  endtask

  task automatic apply_vec(input int v);
    @(negedge clk);
    set_entries(v);
    req_valid = 1'b1; req_tag = tv[v].tag; req_addr = tv[v].addr; req_be = tv[v].be; resp_ready = 1'b1;
    #1 chk($sformatf("v%0d_req_ready", v), 64'(req_ready), 64'd1);
    @(negedge clk);
    req_valid = 1'b0;
    chk($sformatf("v%0d_latency_n1", v), 64'(resp_valid), 64'd0);
    @(negedge clk);
    chk($sformatf("v%0d_resp_valid", v), 64'(resp_valid), 64'd1);
    chk($sformatf("v%0d_kind", v), 64'(resp_kind), 64'(tv[v].kind));
    chk($sformatf("v%0d_tag", v), 64'(resp_tag), 64'(tv[v].tag));
    chk($sformatf("v%0d_data", v), 64'(resp_data), 64'(tv[v].data));
    if (tv[v].kind != 2'b00) chk($sformatf("v%0d_src", v), 64'(resp_src), 64'(tv[v].src));
  endtask

  task automatic step(input logic rv, input logic [2:0] tag, input logic [31:0] addr,
                      input logic [3:0] be, input logic rr);
    logic [1:0] k; logic [2:0] s; logic [31:0] d; exp_t e;
    @(negedge clk);
    req_valid = rv; req_tag = tag; req_addr = addr; req_be = be; resp_ready = rr;
    #1;
    if (held_prev) chk("hold_stable", 64'({resp_valid, resp_kind, resp_tag, resp_src, resp_data}), 64'(held_snap));
    if (resp_valid && resp_ready) begin
      if (exp_q.size() == 0) begin
        chk("resp_expected", 64'(exp_q.size()), 64'd1);
      end else begin
        e = exp_q.pop_front();
        n_resp++;
        chk("sb_tag", 64'(resp_tag), 64'(e.tag));
        chk("sb_kind", 64'(resp_kind), 64'(e.kind));
        chk("sb_data", 64'(resp_data), 64'(e.data));
        if (e.kind != 2'b00) chk("sb_src", 64'(resp_src), 64'(e.src));
      end
    end
    held_prev = resp_valid && !resp_ready;
    held_snap = {resp_valid, resp_kind, resp_tag, resp_src, resp_data};
    if (req_valid && req_ready) begin
      ref_lookup(head_ptr, tag, addr, be, k, s, d);
      exp_q.push_back('{tag: tag, kind: k, src: s, data: d});
      chk("inflight_le2", 64'(exp_q.size() <= 2), 64'd1);
    end
  endtask

  task automatic drain(input string name);
    for (int c = 0; c < 10 && exp_q.size() != 0; c++) step(1'b0, 3'd0, 32'd0, 4'h0, 1'b1);
    chk(name, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; req_valid = 1'b0; resp_ready = 1'b1;
    #1;
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_fields", 64'({resp_kind, resp_tag, resp_src, resp_data}), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete(); held_prev = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //          head  tag   addr      be    valid  store  dv     match  ent_be        kind   src   data
    tv[0]  = '{3'd4, 3'd7, 32'h40, 4'hF, 8'h70, 8'h70, 8'h70, 8'h70, 32'hFFFF_FFFF, 2'b01, 3'd6, 32'hD6C6_B6A6};
    tv[1]  = '{3'd5, 3'd2, 32'h80, 4'hF, 8'h42, 8'h42, 8'h42, 8'h42, 32'hFFFF_FFFF, 2'b01, 3'd1, 32'hD1C1_B1A1};
    tv[2]  = '{3'd2, 3'd2, 32'h80, 4'hF, 8'h42, 8'h42, 8'h42, 8'h42, 32'hFFFF_FFFF, 2'b00, 3'd0, 32'h0};
    tv[3]  = '{3'd0, 3'd4, 32'h40, 4'hF, 8'h08, 8'h08, 8'h08, 8'h08, 32'hFFFF_3FFF, 2'b10, 3'd3, 32'h0};
    tv[4]  = '{3'd0, 3'd4, 32'h40, 4'hF, 8'h08, 8'h08, 8'h00, 8'h08, 32'hFFFF_FFFF, 2'b10, 3'd3, 32'h0};
    tv[5]  = '{3'd0, 3'd4, 32'h40, 4'h3, 8'h04, 8'h04, 8'h04, 8'h04, 32'hFFFF_FFFF, 2'b01, 3'd2, 32'h0000_B2A2};
    tv[6]  = '{3'd0, 3'd4, 32'h40, 4'h3, 8'h04, 8'h04, 8'h04, 8'h04, 32'hFFFF_FCFF, 2'b00, 3'd0, 32'h0};
    tv[7]  = '{3'd0, 3'd5, 32'h40, 4'hF, 8'h0A, 8'h0A, 8'h02, 8'h0A, 32'hFFFF_FFFF, 2'b10, 3'd3, 32'h0};
    tv[8]  = '{3'd0, 3'd5, 32'h40, 4'hF, 8'h0A, 8'h02, 8'h0A, 8'h0A, 32'hFFFF_FFFF, 2'b01, 3'd1, 32'hD1C1_B1A1};
    tv[9]  = '{3'd0, 3'd5, 32'h40, 4'hF, 8'h02, 8'h02, 8'h02, 8'h00, 32'hFFFF_FFFF, 2'b00, 3'd0, 32'h0};
    tv[10] = '{3'd0, 3'd3, 32'h40, 4'hF, 8'h18, 8'h18, 8'h18, 8'h18, 32'hFFFF_FFFF, 2'b00, 3'd0, 32'h0};
    tv[11] = '{3'd0, 3'd5, 32'h40, 4'hF, 8'h00, 8'h0A, 8'h0A, 8'h0A, 32'hFFFF_FFFF, 2'b00, 3'd0, 32'h0};

    reset = 1'b1; flush = 1'b0; req_valid = 1'b0; resp_ready = 1'b1;
    req_tag = 3'd0; req_addr = 32'd0; req_be = 4'h0; head_ptr = 3'd0;
    ent_valid = 8'h00; ent_is_store = 8'h00; ent_data_valid = 8'h00; ent_be = 32'd0; ent_addr = '0;
    for (int i = 0; i < 8; i++) ent_data[i*32 +: 32] = 32'hD0C0_B0A0 | (32'(i) * 32'h0101_0101);
    do_reset();

    for (int v = 0; v < 12; v++) apply_vec(v);

    // Output held low for 3 cycles while requests keep arriving.
    set_entries(0);
    n_resp = 0;
    step(1'b1, 3'd7, 32'h40, 4'hF, 1'b0);
    step(1'b1, 3'd5, 32'h40, 4'hF, 1'b0);
    for (int c = 0; c < 3; c++) begin
      step(1'b1, 3'd6, 32'h40, 4'h3, 1'b0);
      chk("bp_req_ready_low", 64'(req_ready), 64'd0);
      chk("bp_resp_valid", 64'(resp_valid), 64'd1);
    end
    step(1'b1, 3'd6, 32'h40, 4'h3, 1'b1);
    drain("bp_drain");
    chk("bp_resp_count", 64'(n_resp), 64'd3);

    // Flush, then reset, with both stages occupied.
    for (int m = 0; m < 2; m++) begin
      step(1'b1, 3'd7, 32'h40, 4'hF, 1'b0);
      step(1'b1, 3'd5, 32'h40, 4'hF, 1'b0);
      @(negedge clk);
      req_valid = 1'b1; req_tag = 3'd6; resp_ready = 1'b0;
      if (m == 0) flush = 1'b1; else reset = 1'b1;
      #1;
      if (m == 1) begin
        chk("midrst_resp_valid", 64'(resp_valid), 64'd0);
        chk("midrst_req_ready", 64'(req_ready), 64'd1);
        chk("midrst_fields", 64'({resp_kind, resp_tag, resp_src, resp_data}), 64'd0);
      end
      @(negedge clk);
      flush = 1'b0; reset = 1'b0; req_valid = 1'b0; resp_ready = 1'b1;
      exp_q.delete(); held_prev = 1'b0;
      #1;
      chk($sformatf("kill%0d_req_ready", m), 64'(req_ready), 64'd1);
      for (int c = 0; c < 3; c++) begin
        chk($sformatf("kill%0d_no_resp", m), 64'(resp_valid), 64'd0);
        @(negedge clk);
      end
    end

    // Randomized bursts against the reference model; entries fixed within a burst.
    for (int b = 0; b < 25; b++) begin
      head_ptr = 3'($urandom_range(0, 7));
      ent_valid = 8'($urandom); ent_is_store = 8'($urandom);
      ent_data_valid = 8'($urandom); ent_be = $urandom;
      for (int i = 0; i < 8; i++) begin
        ent_addr[i*32 +: 32] = 32'h200 + 32'($urandom_range(0, 2)) * 32'd4;
        ent_data[i*32 +: 32] = $urandom;
      end
      for (int c = 0; c < 30; c++)
        step($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
             32'h200 + 32'($urandom_range(0, 2)) * 32'd4, 4'($urandom_range(1, 15)),
             $urandom_range(0, 2) != 0);
      drain("rand_drain");
    end

`ifdef LSQ_FWD_STATS_EN
    do_reset();
    apply_vec(0); apply_vec(1); apply_vec(5);
    apply_vec(2); apply_vec(6); apply_vec(3);
    @(negedge clk);
    @(negedge clk);
    chk("stat_hit", 64'(stat_hit), 64'd3);
    chk("stat_miss", 64'(stat_miss), 64'd2);
    chk("stat_stall", 64'(stat_stall), 64'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("stat_hit_after_flush", 64'(stat_hit), 64'd3);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
